// File: rtl/stim_pkt_gen.sv
// stim_pkt_gen: byte-stream frame generator (preamble, SFD, counting payload,
// XOR checksum) that drives a receive interface with rxd/rx_dv semantics.
module stim_pkt_gen #(
    parameter int LEN_W   = 16,
    parameter int PRE_LEN = 7,
    parameter int IFG_MIN = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [15:0]      i_frame_num,
    input  logic [LEN_W-1:0] i_frame_len,
    input  logic [7:0]       i_ifg,
    input  logic [7:0]       i_seed,
    output logic [7:0]       o_txd,
    output logic             o_tx_dv,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      o_frame_cnt
);

    localparam int CNT_W = (LEN_W > 8) ? LEN_W : 8;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        PAY,
        CHK,
        IFG,
        DONE
    } state_t;

    state_t           state_q;
    logic             start_pend_q;
    logic             stop_q;
    logic [CNT_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       ifg_q;
    logic [7:0]       seed_q;
    logic [15:0]      num_q;
    logic [15:0]      frame_cnt_q;
    logic [7:0]       csum_q;
    logic [7:0]       txd_q;
    logic             tx_dv_q;
    logic             busy_q;
    logic             done_q;

    logic [7:0]       pay_byte;
    logic [7:0]       csum_d;
    logic [15:0]      frame_cnt_d;
    logic             last_frame;
    logic             stop_seen;

    // Current payload byte, running checksum and end-of-run decisions
    always_comb begin
        pay_byte    = seed_q + frame_cnt_q[7:0] + cnt_q[7:0];
        csum_d      = csum_q ^ pay_byte;
        frame_cnt_d = frame_cnt_q + 16'd1;
        last_frame  = (num_q != '0) && (frame_cnt_d == num_q);
        stop_seen   = stop_q | i_stop;
    end

    // Frame FSM; outputs are loaded on the edge that enters each state so
    // they line up with the state, and a start takes one idle cycle to
    // show its first preamble byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_pend_q <= 1'b0;
            stop_q       <= 1'b0;
            cnt_q        <= '0;
            len_q        <= '0;
            ifg_q        <= '0;
            seed_q       <= '0;
            num_q        <= '0;
            frame_cnt_q  <= '0;
            csum_q       <= '0;
            txd_q        <= '0;
            tx_dv_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_pend_q) begin
                        start_pend_q <= 1'b0;
                        state_q      <= PRE;
                        cnt_q        <= '0;
                        txd_q        <= 8'h55;
                        tx_dv_q      <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (i_start) begin
                        start_pend_q <= 1'b1;
                        len_q        <= (i_frame_len == '0) ? LEN_W'(1) : i_frame_len;
                        ifg_q        <= (i_ifg < 8'(IFG_MIN)) ? 8'(IFG_MIN) : i_ifg;
                        seed_q       <= i_seed;
                        num_q        <= i_frame_num;
                        frame_cnt_q  <= '0;
                        csum_q       <= '0;
                        stop_q       <= 1'b0;
                    end
                end
                PRE: begin
                    stop_q <= stop_seen;
                    if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
                        state_q <= SFD;
                        txd_q   <= 8'hD5;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SFD: begin
                    stop_q  <= stop_seen;
                    state_q <= PAY;
                    cnt_q   <= '0;
                    txd_q   <= seed_q + frame_cnt_q[7:0];
                end
                PAY: begin
                    stop_q <= stop_seen;
                    csum_q <= csum_d;
                    if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) begin
                        state_q <= CHK;
                        txd_q   <= csum_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        txd_q <= pay_byte + 8'd1;
                    end
                end
                CHK: begin
                    frame_cnt_q <= frame_cnt_d;
                    cnt_q       <= '0;
                    txd_q       <= '0;
                    tx_dv_q     <= 1'b0;
                    if (last_frame || stop_seen) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= IFG;
                    end
                end
                IFG: begin
                    csum_q <= '0;
                    if (i_stop) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (cnt_q == CNT_W'(ifg_q) - CNT_W'(1)) begin
                        state_q <= PRE;
                        cnt_q   <= '0;
                        txd_q   <= 8'h55;
                        tx_dv_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_txd       = txd_q;
    assign o_tx_dv     = tx_dv_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_stim_pkt_gen.sv
// tb_stim_pkt_gen: directed table of runs for stim_pkt_gen plus a reset-mid-frame sequence.
module tb_stim_pkt_gen;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_stop;
    logic [15:0] i_frame_num;
    logic [15:0] i_frame_len;
    logic [7:0]  i_ifg;
    logic [7:0]  i_seed;
    logic [7:0]  o_txd;
    logic        o_tx_dv;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_frame_cnt;

    int n_checks;
    int n_errors;

    stim_pkt_gen #(.LEN_W(16), .PRE_LEN(7), .IFG_MIN(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_frame_num (i_frame_num),
        .i_frame_len (i_frame_len),
        .i_ifg       (i_ifg),
        .i_seed      (i_seed),
        .o_txd       (o_txd),
        .o_tx_dv     (o_tx_dv),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_frame_cnt (o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One run: config, hand-computed bytes of frames 0/1, last checksum,
    // frame count, expected gap, and optional stop / stray-start frame.
    typedef struct {
        logic [15:0] len;
        logic [7:0]  seed;
        logic [15:0] num;
        logic [7:0]  ifg;
        int          n_pay;
        logic [23:0] pay0;
        logic [7:0]  chk0;
        logic [23:0] pay1;
        logic [7:0]  chk1;
        logic [7:0]  last_chk;
        int          frames;
        int          gap;
        int          stop_frame;
        int          glitch_frame;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] len, input logic [7:0] seed,
                                input logic [15:0] num, input logic [7:0] ifg,
                                input int n_pay, input logic [23:0] pay0,
                                input logic [7:0] chk0, input logic [23:0] pay1,
                                input logic [7:0] chk1, input logic [7:0] last_chk,
                                input int frames, input int gap,
                                input int stop_frame, input int glitch_frame);
        vec_t v;
        v.len = len; v.seed = seed; v.num = num; v.ifg = ifg;
        v.n_pay = n_pay; v.pay0 = pay0; v.chk0 = chk0; v.pay1 = pay1;
        v.chk1 = chk1; v.last_chk = last_chk; v.frames = frames; v.gap = gap;
        v.stop_frame = stop_frame; v.glitch_frame = glitch_frame;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic       dv_log[$];
        logic [7:0] txd_log[$];
        bit         done_seen;
        int         bad;
        int         bad_pre;
        int         pos;
        int         frames_seen;
        int         i;
        int         g;
        int         s;
        int         fr;
        int         trail;
        int         last_s;
        int         n;
        logic [23:0] pw;
        logic [7:0]  ch;
        logic [7:0]  exp_b;
        logic [15:0] cnt_at_done;

        i_frame_len = v.len;
        i_seed      = v.seed;
        i_frame_num = v.num;
        i_ifg       = v.ifg;
        i_stop      = 1'b0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("latency_busy_low", o_busy, 0);
        chk("latency_dv_low", o_tx_dv, 0);
        @(negedge clk);
        chk("first_busy", o_busy, 1);
        chk("first_byte", o_txd, 8'h55);

        done_seen = 0; bad = 0; pos = 0; frames_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            if (o_done) begin
                done_seen = 1;
                break;
            end
            if (!o_tx_dv && o_txd != 8'h00) bad++;
            if (!o_busy) bad++;
            if (o_tx_dv) begin
                if (pos == 0) frames_seen++;
                pos++;
            end else begin
                pos = 0;
            end
            if (v.stop_frame != 0 && frames_seen == v.stop_frame && pos == 9) i_stop = 1'b1;
            if (v.glitch_frame != 0 && frames_seen == v.glitch_frame && pos == 3) i_start = 1'b1;
            else i_start = 1'b0;
            dv_log.push_back(o_tx_dv);
            txd_log.push_back(o_txd);
        end
        i_stop  = 1'b0;
        i_start = 1'b0;

        chk("done_seen", done_seen, 1);
        chk("busy_or_idle_byte_violations", bad, 0);
        if (done_seen) begin
            chk("done_busy_low", o_busy, 0);
            chk("done_dv_low", o_tx_dv, 0);
            chk("frame_cnt_at_done", o_frame_cnt, v.frames);
        end

        n = dv_log.size();
        i = 0; fr = 0; trail = 0; last_s = -1; bad_pre = 0;
        while (i < n) begin
            g = 0;
            while (i < n && !dv_log[i]) begin
                g++;
                i++;
            end
            if (i >= n) begin
                trail = g;
                break;
            end
            if (fr > 0) chk($sformatf("gap_before_f%0d", fr), g, v.gap);
            s = i;
            while (i < n && dv_log[i]) i++;
            chk($sformatf("frame_len_f%0d", fr), i - s, 9 + v.n_pay);
            for (int p = 0; p < 7; p++) if (txd_log[s + p] != 8'h55) bad_pre++;
            chk($sformatf("sfd_f%0d", fr), txd_log[s + 7], 8'hD5);
            if (fr < 2) begin
                pw = (fr == 0) ? v.pay0 : v.pay1;
                ch = (fr == 0) ? v.chk0 : v.chk1;
                for (int k = 0; k < v.n_pay; k++) begin
                    exp_b = pw[23 - 8 * k -: 8];
                    chk($sformatf("pay_f%0d_b%0d", fr, k), txd_log[s + 8 + k], exp_b);
                end
                chk($sformatf("checksum_f%0d", fr), txd_log[s + 8 + v.n_pay], ch);
            end
            last_s = s;
            fr++;
        end
        chk("preamble_bytes_wrong", bad_pre, 0);
        chk("frames_on_wire", fr, v.frames);
        chk("gap_after_last_frame", trail, 0);
        if (last_s >= 0) chk("last_checksum", txd_log[last_s + 8 + v.n_pay], v.last_chk);

        // start raised while o_done is showing must be ignored
        cnt_at_done = o_frame_cnt;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("done_one_cycle", o_done, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("start_during_done_ignored", {o_busy, o_tx_dv}, 2'b00);
        end
        chk("frame_cnt_held", o_frame_cnt, cnt_at_done);
    endtask

    vec_t tbl[7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_stop = 1'b0;
        i_frame_num = '0;
        i_frame_len = '0;
        i_ifg = '0;
        i_seed = '0;

        //            len     seed   num    ifg   n  pay0        chk0   pay1        chk1   last   fr gap stop glitch
        tbl[0] = mk(16'd3, 8'h10, 16'd1, 8'd12, 3, 24'h101112, 8'h13, 24'h000000, 8'h00, 8'h13, 1, 12, 0, 0);
        tbl[1] = mk(16'd3, 8'h10, 16'd2, 8'd20, 3, 24'h101112, 8'h13, 24'h111213, 8'h10, 8'h10, 2, 20, 0, 0);
        tbl[2] = mk(16'd3, 8'h10, 16'd2, 8'd3,  3, 24'h101112, 8'h13, 24'h111213, 8'h10, 8'h10, 2, 12, 0, 0);
        tbl[3] = mk(16'd0, 8'hFE, 16'd1, 8'd12, 1, 24'hFE0000, 8'hFE, 24'h000000, 8'h00, 8'hFE, 1, 12, 0, 0);
        tbl[4] = mk(16'd3, 8'hFE, 16'd1, 8'd12, 3, 24'hFEFF00, 8'h01, 24'h000000, 8'h00, 8'h01, 1, 12, 0, 0);
        tbl[5] = mk(16'd1, 8'h80, 16'd2, 8'd13, 1, 24'h800000, 8'h80, 24'h810000, 8'h81, 8'h81, 2, 13, 0, 0);
        tbl[6] = mk(16'd3, 8'h20, 16'd0, 8'd12, 3, 24'h202122, 8'h23, 24'h212223, 8'h20, 8'h22, 4, 12, 4, 2);

        repeat (2) @(negedge clk);
        chk("reset_txd", o_txd, 8'h00);
        chk("reset_ctrl", {o_tx_dv, o_busy, o_done}, 3'b000);
        chk("reset_frame_cnt", o_frame_cnt, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 7; t++) run_vec(tbl[t]);

        // reset dropped during payload: outputs clear at once, no done
        begin
            bit found;
            int bad_r;
            found = 0;
            i_frame_len = 16'd3; i_seed = 8'h40; i_frame_num = 16'd1; i_ifg = 8'd12;
            @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (o_tx_dv && o_txd == 8'h40) begin
                    found = 1;
                    break;
                end
            end
            chk("reached_payload_before_reset", found, 1);
            #2 rst_n = 1'b0;
            #1;
            chk("async_reset_dv", o_tx_dv, 0);
            chk("async_reset_txd", o_txd, 8'h00);
            chk("async_reset_busy", o_busy, 0);
            chk("async_reset_cnt", o_frame_cnt, 16'h0000);
            bad_r = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (o_done || o_tx_dv) bad_r++;
            end
            rst_n = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (o_done || o_tx_dv || o_busy) bad_r++;
            end
            chk("quiet_after_reset", bad_r, 0);
            run_vec(mk(16'd3, 8'h40, 16'd1, 8'd12, 3, 24'h404142, 8'h43, 24'h000000, 8'h00, 8'h43, 1, 12, 0, 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stim_pkt_gen.md
# stim_pkt_gen

Synthesizable byte-stream frame generator for the test_top bench. It drives the DUT receive side (`rxd`/`rx_dv`) directly upstream of the DUT. Each frame carries a preamble, an SFD, a deterministic payload and an XOR checksum. The bench starts it with a pulse and waits for `o_done`; the output-side monitor checks frames without a reference model.

## Interface

Parameters:
- `LEN_W`, 16, width of payload-length input
- `PRE_LEN`, 7, preamble byte count (value 0x55)
- `IFG_MIN`, 12, minimum inter-frame gap in cycles

Ports:
- `clk`  in  1  bench clock (clk_gen output)
- `rst_n`  in  1  asynchronous, active-low reset
- `i_start`  in  1  start pulse; sampled only in IDLE
- `i_stop`  in  1  level; finish current frame, then end the run
- `i_frame_num`  in  16  frames per run; 0 = continuous until `i_stop`
- `i_frame_len`  in  LEN_W  payload bytes per frame; 0 treated as 1
- `i_ifg`  in  8  gap cycles; values below IFG_MIN clamp to IFG_MIN
- `i_seed`  in  8  payload seed
- `o_txd`  out  8  byte to DUT `rxd`
- `o_tx_dv`  out  1  byte valid, to DUT `rx_dv`
- `o_busy`  out  1  high from the cycle after start accepted until `o_done`
- `o_done`  out  1  one-cycle pulse at end of run
- `o_frame_cnt`  out  16  frames completed this run (wraps at 0xFFFF)

## Operation

- One clock. Reset is asynchronous and active-low, named `rst_n`.
- FSM states: IDLE, PRE, SFD, PAY, CHK, IFG, DONE.
- IDLE:
  - On `i_start`=1, latch all `i_*` config.
  - Clear `o_frame_cnt`, frame index f, and the checksum.
  - Go to PRE.
- PRE: PRE_LEN cycles, `o_txd`=0x55. Then SFD.
- SFD: one cycle, `o_txd`=0xD5. Then PAY.
- PAY:
  - L cycles (L = latched length, min 1).
  - Byte k (0..L-1) = (seed + f + k) mod 256; all sums truncated to 8 bits.
  - Checksum accumulates the XOR of the payload bytes.
- CHK:
  - One cycle, `o_txd` = checksum; `o_frame_cnt`++, f++.
  - If last frame, or `i_stop` sampled high in any state from PRE through CHK: go to DONE.
  - Otherwise go to IFG.
- IFG: max(`i_ifg`, IFG_MIN) cycles with `o_tx_dv`=0, then PRE. Checksum cleared.
  - An `i_stop` sampled in IFG goes directly to DONE.
- Last frame: `o_frame_cnt` reaches `i_frame_num` (`i_frame_num` ≠ 0).
- DONE: one cycle, `o_done`=1, `o_busy`=0. Then IDLE. No trailing gap after the final frame.
- `o_tx_dv`=1 exactly in PRE/SFD/PAY/CHK; `o_txd`=0x00 whenever `o_tx_dv`=0.
- Outside IDLE, `i_start` is ignored and config inputs are not re-sampled.

## Timing

- All outputs are registered.
- Reset values: `o_txd`=0, `o_tx_dv`=0, `o_busy`=0, `o_done`=0, `o_frame_cnt`=0, FSM=IDLE.
- Start latency: `i_start` sampled at edge N; first 0x55 and `o_busy`=1 appear after edge N+1.
- Frame length: PRE_LEN+1+L+1 cycles valid (L+9 with default parameters), with no bubbles inside a frame.
- Gap: exactly max(`i_ifg`,12) low cycles between a CHK byte and the next preamble byte.
- `o_done`: asserts the cycle after the final CHK byte.
- `o_frame_cnt`: updates on the same edge that ends CHK.
- `i_start` while `o_done`=1: ignored (FSM is in DONE, not IDLE). Accepted from the following cycle.
- `rst_n` low mid-frame: all outputs go to reset values immediately (asynchronous), with no partial-frame completion. After release, the block waits in IDLE for a new `i_start`.
- Continuous mode: when `o_frame_cnt` wraps 0xFFFF→0 the run does not end.

## Test plan

- Single frame, len=3, seed=0x10, num=1 → 55×7, D5, 10 11 12, 13; `o_done` one cycle after 0x13; `o_frame_cnt`=1.
- num=2, len=3, seed=0x10, ifg=20 → 20 low cycles between frames; second frame payload 11 12 13, checksum 0x10; `o_frame_cnt`=2.
- ifg=3, num=2 → gap is exactly 12 cycles.
- len=0, seed=0xFE → one payload byte 0xFE, checksum 0xFE. Then len=3, seed=0xFE → FE FF 00, checksum 0x01.
- num=0 (continuous), `i_stop` raised in frame 4 PAY → frame 4 completes intact; `o_done` follows its CHK; `o_frame_cnt`=4. An `i_start` pulse mid-run has no effect.
- `rst_n` dropped during PAY → `o_tx_dv`/`o_txd`/`o_busy` go to 0 the same cycle, with no `o_done`. A fresh start afterwards produces a correct frame with `o_frame_cnt` counting from 0.
